mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: width of adr and ld_adr.
REQ-002 SHALL have parameter DATA_W, default 8: byte-wide data path.
REQ-003 SHALL have parameter DEPTH, default 256: number of storage words, 1 to 2^ADDR_W.
REQ-004 SHALL have parameter WAIT, default 2, range 0..15: wait states inserted per access.
REQ-005 SHALL have port clk, input, 1: single clock, all logic on the rising edge.
REQ-006 SHALL have port rst, input, 1: reset, synchronous and active-low.
REQ-007 SHALL have port memread, input, 1: read request from the controller.
REQ-008 SHALL have port memwrite, input, 1: write request from the controller.
REQ-009 SHALL have port adr, input, ADDR_W: request address.
REQ-010 SHALL have port writedata, input, DATA_W: write data.
REQ-011 SHALL have port ld_en, input, 1: backdoor preload strobe.
REQ-012 SHALL have port ld_adr, input, ADDR_W: preload address.
REQ-013 SHALL have port ld_data, input, DATA_W: preload data.
REQ-014 SHALL have port memdata, output, DATA_W: registered read data.
REQ-015 SHALL have port memready, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port err, output, 1: one-cycle protocol-error pulse.

Function
REQ-017 SHALL implement FSM states IDLE, WAITST and RESP.
REQ-018 In IDLE, SHALL sample memread/memwrite each edge; when exactly one is high at edge N, SHALL latch adr, writedata and op.
REQ-019 On acceptance, SHALL load wait counter with WAIT and go to WAITST (WAIT>0) or RESP (WAIT=0).
REQ-020 In WAITST, SHALL decrement the counter each edge and go to RESP on the edge where the counter reaches 0.
REQ-021 On entering RESP (edge N+1+WAIT), SHALL commit the latched write to the array or register the array read into memdata.
REQ-022 SHALL hold memready high for exactly the one cycle in RESP, with memdata valid in that cycle.
REQ-023 RESP SHALL always return to IDLE; a request still high in IDLE SHALL be accepted as a new access, so back-to-back fetches cost WAIT+2 cycles each.
REQ-024 Request inputs SHALL be ignored in WAITST and RESP; the latched adr/writedata/op govern the access.
REQ-025 memdata SHALL hold its last read value through writes, errors and idle cycles.
REQ-026 If memread and memwrite are both high at an IDLE edge, SHALL perform no access, pulse err for one cycle and stay in IDLE.
REQ-027 Address SHALL index modulo DEPTH (low log2(DEPTH) bits); no out-of-range error.
REQ-028 ld_en SHALL write ld_data to ld_adr only while in IDLE and SHALL be ignored in other states.
REQ-029 ld_en SHALL be allowed in the same IDLE cycle as a request acceptance; the accepted access SHALL observe the preloaded value.
REQ-030 A read in RESP SHALL return data written by any earlier-committed write, including one in the immediately preceding access.

Reset
REQ-031 When rst is low at an edge, SHALL set state IDLE, memdata 0, memready 0, err 0 and counter 0.
REQ-032 Reset mid-access SHALL abort the access and SHALL NOT commit a pending write.
REQ-033 Array contents SHALL NOT be reset.

Structure
REQ-034 A shared package mem_pkg SHALL hold the state typedef (IDLE/WAITST/RESP), the default widths and the WAIT counter width.
REQ-035 Storage SHALL be one sub-module mem_array: synchronous one-write, one-read byte RAM; write port muxed between the backdoor and the RESP commit.

Verification
REQ-036 Preload 0x10 to 0xA5; memread, adr=0x10, WAIT=2 -> memready exactly 3 cycles after acceptance edge, memdata=0xA5, single-cycle pulse.
REQ-037 memwrite, adr=0x20, writedata=0x3C, then memread, adr=0x20 -> read returns 0x3C; memdata keeps its prior value during the write.
REQ-038 Four consecutive reads at adr 0..3 with memread held high, WAIT=0 -> four memready pulses 2 cycles apart with the correct bytes.
REQ-039 memread=memwrite=1 in IDLE -> err high for 1 cycle, no memready, array unchanged at adr.
REQ-040 rst low during WAITST of a write of 0xFF to 0x05 -> outputs 0, state IDLE; a later read of 0x05 returns the old value.
REQ-041 DEPTH=16, write 0x77 to adr 0x13 -> read of adr 0x03 returns 0x77; ld_en pulsed in WAITST -> no array change.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and defaults for the wait-state memory responder.
package mem_pkg;

   localparam int DEF_ADDR_W = 8;
   localparam int DEF_DATA_W = 8;
   localparam int DEF_DEPTH  = 256;
   localparam int DEF_WAIT   = 2;
   localparam int CNT_W      = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAITST = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Index width of the storage array; a one-word array still needs one index bit.
   function automatic int idx_width(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/mem_array.sv
// Byte RAM with one synchronous write port and one registered read port.
// Addresses wrap modulo DEPTH; the read register resets, the array does not.
module mem_array
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] wadr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] radr,
   output logic [DATA_W-1:0] rdata
);

   localparam int IDX_W = idx_width(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [IDX_W-1:0]  widx;
   logic [IDX_W-1:0]  ridx;

   // DEPTH is a power of two, so masking keeps the low log2(DEPTH) bits.
   assign widx = IDX_W'(wadr & ADDR_W'(DEPTH - 1));
   assign ridx = IDX_W'(radr & ADDR_W'(DEPTH - 1));

   always_ff @(posedge clk) begin
      if (we) begin
         mem[widx] <= wdata;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[ridx];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// Memory responder: accepts one read or write per request, inserts WAIT wait
// states, then pulses memready with registered read data.
module mem_responder
   import mem_pkg::*;
#(
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int DATA_W = DEF_DATA_W,
   parameter int DEPTH  = DEF_DEPTH,
   parameter int WAIT   = DEF_WAIT
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              memread,
   input  logic              memwrite,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] writedata,
   input  logic              ld_en,
   input  logic [ADDR_W-1:0] ld_adr,
   input  logic [DATA_W-1:0] ld_data,
   output logic [DATA_W-1:0] memdata,
   output logic              memready,
   output logic              err
);

   state_t            state;
   state_t            state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic [CNT_W-1:0]  cnt_nxt;
   logic              accept;
   logic              ready_nxt;
   logic              err_nxt;

   logic              op_wr;
   logic [ADDR_W-1:0] adr_q;
   logic [DATA_W-1:0] wdata_q;

   logic              ld_we;
   logic              commit;
   logic              arr_we;
   logic              arr_re;
   logic [ADDR_W-1:0] arr_wadr;
   logic [DATA_W-1:0] arr_wdata;

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      accept    = 1'b0;
      ready_nxt = 1'b0;
      err_nxt   = 1'b0;
      case (state)
         IDLE: begin
            if (memread ^ memwrite) begin
               accept    = 1'b1;
               cnt_nxt   = CNT_W'(WAIT);
               state_nxt = (WAIT == 0) ? RESP : WAITST;
            end else if (memread && memwrite) begin
               err_nxt = 1'b1;
            end
         end
         WAITST: begin
            cnt_nxt = (cnt == '0) ? '0 : cnt - 1'b1;
            // Leave on the edge that brings the counter to zero.
            if (cnt <= CNT_W'(1)) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            state_nxt = IDLE;
            ready_nxt = 1'b1;
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         memready <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_nxt;
         cnt      <= cnt_nxt;
         memready <= ready_nxt;
         err      <= err_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (accept) begin
         adr_q   <= adr;
         wdata_q <= writedata;
         op_wr   <= memwrite;
      end
   end

   // Backdoor preload only in IDLE, commit only in RESP, so the write port never collides.
   // Both are blocked while reset is held so an aborted write is never committed.
   assign ld_we     = (state == IDLE) && ld_en;
   assign commit    = (state == RESP) && op_wr;
   assign arr_we    = rst && (ld_we || commit);
   assign arr_wadr  = commit ? adr_q : ld_adr;
   assign arr_wdata = commit ? wdata_q : ld_data;
   assign arr_re    = (state == RESP) && !op_wr;

   mem_array #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .DEPTH (DEPTH)
   ) u_array (
      .clk  (clk),
      .rst  (rst),
      .we   (arr_we),
      .wadr (arr_wadr),
      .wdata(arr_wdata),
      .re   (arr_re),
      .radr (adr_q),
      .rdata(memdata)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one WAIT=2/DEPTH=256 instance and one WAIT=0/DEPTH=16
// instance checked against a byte-array model of memory contents and response timing.
module tb_mem_responder;
   import mem_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic            rst;
   logic [1:0]      memread;
   logic [1:0]      memwrite;
   logic [1:0][7:0] adr;
   logic [1:0][7:0] writedata;
   logic [1:0]      ld_en;
   logic [1:0][7:0] ld_adr;
   logic [1:0][7:0] ld_data;
   logic [1:0][7:0] memdata;
   logic [1:0]      memready;
   logic [1:0]      err;

   mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(256), .WAIT(2)) dut0 (
      .clk(clk), .rst(rst), .memread(memread[0]), .memwrite(memwrite[0]),
      .adr(adr[0]), .writedata(writedata[0]), .ld_en(ld_en[0]),
      .ld_adr(ld_adr[0]), .ld_data(ld_data[0]), .memdata(memdata[0]),
      .memready(memready[0]), .err(err[0])
   );

   mem_responder #(.ADDR_W(8), .DATA_W(8), .DEPTH(16), .WAIT(0)) dut1 (
      .clk(clk), .rst(rst), .memread(memread[1]), .memwrite(memwrite[1]),
      .adr(adr[1]), .writedata(writedata[1]), .ld_en(ld_en[1]),
      .ld_adr(ld_adr[1]), .ld_data(ld_data[1]), .memdata(memdata[1]),
      .memready(memready[1]), .err(err[1])
   );

   // Reference model: memory contents, last returned byte, per-instance geometry.
   logic [7:0] ref_mem [2][256];
   logic [7:0] last_rd [2];
   int         depth_of [2] = '{256, 16};
   int         wait_of  [2] = '{2, 0};

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] model_rd(input int d, input int a);
      return ref_mem[d][a % depth_of[d]];
   endfunction

   task automatic preload(input int d, input int a, input logic [7:0] v);
      @(negedge clk);
      ld_en[d] = 1'b1; ld_adr[d] = 8'(a); ld_data[d] = v;
      @(negedge clk);
      ld_en[d] = 1'b0;
      ref_mem[d][a % depth_of[d]] = v;
   endtask

   // Called at the negedge following the acceptance edge (k0 = 0) or later.
   task automatic wait_ready(input int d, input string tag, input int k0);
      int k;
      bit seen;
      seen = 1'b0;
      for (k = k0; k <= 40; k++) begin
         if (memready[d]) begin
            seen = 1'b1;
            break;
         end
         check({tag, "_hold"}, 32'(memdata[d]), 32'(last_rd[d]));
         @(negedge clk);
      end
      check({tag, "_seen"}, 32'(seen), 32'd1);
      if (seen) check({tag, "_lat"}, 32'(k), 32'(wait_of[d] + 1));
   endtask

   task automatic finish_pulse(input int d, input string tag);
      @(negedge clk);
      check({tag, "_pulse"}, 32'(memready[d]), 32'd0);
   endtask

   task automatic do_read(input int d, input int a, input string tag);
      logic [7:0] exp;
      exp = model_rd(d, a);
      @(negedge clk);
      memread[d] = 1'b1; adr[d] = 8'(a);
      @(negedge clk);
      memread[d] = 1'b0; adr[d] = 8'($urandom_range(0, 255));
      wait_ready(d, tag, 0);
      check({tag, "_data"}, 32'(memdata[d]), 32'(exp));
      last_rd[d] = exp;
      finish_pulse(d, tag);
   endtask

   task automatic do_write(input int d, input int a, input logic [7:0] v, input string tag);
      @(negedge clk);
      memwrite[d] = 1'b1; adr[d] = 8'(a); writedata[d] = v;
      @(negedge clk);
      memwrite[d] = 1'b0; writedata[d] = 8'($urandom_range(0, 255));
      wait_ready(d, tag, 0);
      check({tag, "_wrhold"}, 32'(memdata[d]), 32'(last_rd[d]));
      ref_mem[d][a % depth_of[d]] = v;
      finish_pulse(d, tag);
   endtask

   task automatic do_err(input int d, input int a, input logic [7:0] v, input string tag);
      @(negedge clk);
      memread[d] = 1'b1; memwrite[d] = 1'b1; adr[d] = 8'(a); writedata[d] = v;
      @(negedge clk);
      memread[d] = 1'b0; memwrite[d] = 1'b0;
      check({tag, "_err"}, 32'(err[d]), 32'd1);
      check({tag, "_nordy"}, 32'(memready[d]), 32'd0);
      @(negedge clk);
      check({tag, "_errlow"}, 32'(err[d]), 32'd0);
      check({tag, "_nordy2"}, 32'(memready[d]), 32'd0);
      check({tag, "_hold"}, 32'(memdata[d]), 32'(last_rd[d]));
   endtask

   initial begin
      rst = 1'b0;
      memread = '0; memwrite = '0; adr = '0; writedata = '0;
      ld_en = '0; ld_adr = '0; ld_data = '0;
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      repeat (2) @(negedge clk);
      for (int d = 0; d < 2; d++) begin
         check("rst_memdata", 32'(memdata[d]), 32'd0);
         check("rst_memready", 32'(memready[d]), 32'd0);
         check("rst_err", 32'(err[d]), 32'd0);
      end
      check("rst_state0", 32'(dut0.state), 32'(IDLE));
      rst = 1'b1;

      // Give every location a known value.
      for (int a = 0; a < 256; a++) preload(0, a, 8'($urandom_range(0, 255)));
      for (int a = 0; a < 16; a++) preload(1, a, 8'($urandom_range(0, 255)));

      preload(0, 8'h10, 8'hA5);
      do_read(0, 8'h10, "rd_preload");

      do_write(0, 8'h20, 8'h3C, "wr_20");
      do_read(0, 8'h20, "rd_20");

      // Back-to-back reads, request held high on the WAIT=0 instance.
      @(negedge clk);
      memread[1] = 1'b1; adr[1] = 8'd0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("b2b_gap", 32'(memready[1]), 32'd0);
         adr[1] = 8'(i + 1);
         @(negedge clk);
         check("b2b_rdy", 32'(memready[1]), 32'd1);
         check("b2b_data", 32'(memdata[1]), 32'(model_rd(1, i)));
         last_rd[1] = model_rd(1, i);
         if (i == 3) memread[1] = 1'b0;
      end
      finish_pulse(1, "b2b");

      do_err(0, 8'h30, 8'h11, "err_30");
      do_read(0, 8'h30, "rd_after_err");

      // Reset in the middle of a write's wait states.
      preload(0, 8'h05, 8'h5A);
      @(negedge clk);
      memwrite[0] = 1'b1; adr[0] = 8'h05; writedata[0] = 8'hFF;
      @(negedge clk);
      memwrite[0] = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      check("midrst_memdata", 32'(memdata[0]), 32'd0);
      check("midrst_memready", 32'(memready[0]), 32'd0);
      check("midrst_err", 32'(err[0]), 32'd0);
      check("midrst_state", 32'(dut0.state), 32'(IDLE));
      last_rd[0] = 8'h00; last_rd[1] = 8'h00;
      do_read(0, 8'h05, "rd_after_rst");

      do_write(1, 8'h13, 8'h77, "wr_alias");
      do_read(1, 8'h03, "rd_alias");

      // Preload strobe while in WAITST must be ignored.
      @(negedge clk);
      memread[0] = 1'b1; adr[0] = 8'h44;
      @(negedge clk);
      memread[0] = 1'b0;
      ld_en[0] = 1'b1; ld_adr[0] = 8'h44; ld_data[0] = ~model_rd(0, 8'h44);
      @(negedge clk);
      ld_en[0] = 1'b0;
      wait_ready(0, "ld_waitst", 1);
      check("ld_waitst_data", 32'(memdata[0]), 32'(model_rd(0, 8'h44)));
      last_rd[0] = model_rd(0, 8'h44);
      finish_pulse(0, "ld_waitst");
      do_read(0, 8'h44, "rd_after_ldw");

      // Preload strobe while in RESP must be ignored.
      @(negedge clk);
      memread[1] = 1'b1; adr[1] = 8'h07;
      @(negedge clk);
      memread[1] = 1'b0;
      ld_en[1] = 1'b1; ld_adr[1] = 8'h07; ld_data[1] = ~model_rd(1, 8'h07);
      wait_ready(1, "ld_resp", 0);
      ld_en[1] = 1'b0;
      check("ld_resp_data", 32'(memdata[1]), 32'(model_rd(1, 8'h07)));
      last_rd[1] = model_rd(1, 8'h07);
      finish_pulse(1, "ld_resp");
      do_read(1, 8'h07, "rd_after_ldr");

      // Preload in the same cycle as acceptance is seen by that access.
      @(negedge clk);
      memread[0] = 1'b1; adr[0] = 8'h66;
      ld_en[0] = 1'b1; ld_adr[0] = 8'h66; ld_data[0] = 8'hC3;
      ref_mem[0][8'h66] = 8'hC3;
      @(negedge clk);
      memread[0] = 1'b0; ld_en[0] = 1'b0;
      wait_ready(0, "ld_same", 0);
      check("ld_same_data", 32'(memdata[0]), 32'hC3);
      last_rd[0] = 8'hC3;
      finish_pulse(0, "ld_same");

      // Random mix of operations on both instances.
      for (int n = 0; n < 80; n++) begin
         int d;
         int op;
         int a;
         logic [7:0] v;
         d  = int'($urandom_range(0, 1));
         op = int'($urandom_range(0, 3));
         a  = int'($urandom_range(0, 255));
         v  = 8'($urandom_range(0, 255));
         case (op)
            0: do_read(d, a, "rnd_rd");
            1: begin
               do_write(d, a, v, "rnd_wr");
               do_read(d, a, "rnd_rdback");
            end
            2: preload(d, a, v);
            default: begin
               do_err(d, a, v, "rnd_err");
               do_read(d, a, "rnd_rd_err");
            end
         endcase
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
